m_extension_unit: RTL and testbench

Iterative RV32M multiply/divide responder for the 5-stage core. The execute stage issues an M-type instruction with its two forwarded operands. The unit runs the operation over multiple cycles while signalling busy, then returns one result with its destination register and write-enable. The hazard unit uses busy to stall the pipeline; the result is merged into the EX/MEM path on the ready pulse.

---
 rtl/m_extension_unit.sv | 206 ++++++++++++++++++++
 tb/tb_m_extension_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/m_extension_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle. The result, destination and write enable are returned on a single-cycle ready pulse.
module m_extension_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic        invalid_inst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        ready,
    output logic        wr,
    output logic [31:0] result,
    output logic [4:0]  dest
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [2:0]  r_func3;
    logic [4:0]  r_rd;
    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_ready;
    logic        r_wr;
    logic [31:0] r_result;
    logic [4:0]  r_dest;

    logic        w_accept;
    logic        w_unused;
    logic        w_is_div;
    logic        w_op1_neg;
    logic        w_op2_neg;
    logic        w_neg_result;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_div_zero;
    logic        w_overflow;
    logic [31:0] w_special_val;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_sh;
    logic [32:0] w_div_diff;
    logic [63:0] w_step_acc;
    logic [63:0] w_mul_fix;
    logic [31:0] w_div_sel;
    logic [31:0] w_fix_val;

    assign w_accept = (r_state == S_IDLE) && start && !invalid_inst
                   && (instruction[6:0] == 7'b0110011)
                   && (instruction[31:25] == 7'b0000001);
    assign w_unused = ^instruction[24:15];

    // MUL takes the unsigned path: its low word is identical for either signedness.
    assign w_is_div  = r_func3[2];
    assign w_op1_neg = r_op1[31] && ((r_func3 == 3'b001) || (r_func3 == 3'b010)
                                  || (r_func3 == 3'b100) || (r_func3 == 3'b110));
    assign w_op2_neg = r_op2[31] && ((r_func3 == 3'b001) || (r_func3 == 3'b100)
                                  || (r_func3 == 3'b110));
    assign w_neg_result = (w_is_div && r_func3[1]) ? w_op1_neg : (w_op1_neg ^ w_op2_neg);
    assign w_mag1 = w_op1_neg ? (32'd0 - r_op1) : r_op1;
    assign w_mag2 = w_op2_neg ? (32'd0 - r_op2) : r_op2;

    assign w_div_zero = w_is_div && (r_op2 == 32'd0);
    assign w_overflow = w_is_div && !r_func3[0] && (r_op1 == 32'h8000_0000)
                     && (r_op2 == 32'hFFFF_FFFF);

    // Special-case result selection
    always_comb begin
        w_special_val = 32'd0;
        if (w_div_zero) begin
            w_special_val = r_func3[1] ? r_op1 : 32'hFFFF_FFFF;
        end else begin
            w_special_val = r_func3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_div_sh   = r_acc[63:31];
    assign w_div_diff = w_div_sh - {1'b0, r_mcand};

    // One iteration of the active algorithm
    always_comb begin
        w_step_acc = r_acc;
        if (w_is_div) begin
            if (!w_div_diff[32]) begin
                w_step_acc = {w_div_diff[31:0], r_acc[30:0], 1'b1};
            end else begin
                w_step_acc = {w_div_sh[31:0], r_acc[30:0], 1'b0};
            end
        end else begin
            w_step_acc = {w_mul_sum, r_acc[31:1]};
        end
    end

    assign w_mul_fix = w_neg_result ? (64'd0 - r_acc) : r_acc;
    assign w_div_sel = r_func3[1] ? r_acc[63:32] : r_acc[31:0];

    // Final sign correction and word selection
    always_comb begin
        w_fix_val = 32'd0;
        if (w_is_div) begin
            w_fix_val = w_neg_result ? (32'd0 - w_div_sel) : w_div_sel;
        end else if (r_func3 == 3'b000) begin
            w_fix_val = w_mul_fix[31:0];
        end else begin
            w_fix_val = w_mul_fix[63:32];
        end
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op1    <= 32'd0;
            r_op2    <= 32'd0;
            r_func3  <= 3'd0;
            r_rd     <= 5'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 32'd0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_wr     <= 1'b0;
            r_result <= 32'd0;
            r_dest   <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    r_wr    <= 1'b0;
                    if (w_accept) begin
                        r_op1   <= op1;
                        r_op2   <= op2;
                        r_func3 <= instruction[14:12];
                        r_rd    <= instruction[11:7];
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (w_div_zero || w_overflow) begin
                        r_result <= w_special_val;
                        r_dest   <= r_rd;
                        r_ready  <= 1'b1;
                        r_wr     <= (r_rd != 5'd0);
                        r_state  <= S_DONE;
                    end else begin
                        r_acc   <= w_is_div ? {32'd0, w_mag1} : {32'd0, w_mag2};
                        r_mcand <= w_is_div ? w_mag2 : w_mag1;
                        r_cnt   <= 5'd0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_val;
                    r_dest   <= r_rd;
                    r_ready  <= 1'b1;
                    r_wr     <= (r_rd != 5'd0);
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_wr    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_wr    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign ready  = r_ready;
    assign wr     = r_wr;
    assign result = r_result;
    assign dest   = r_dest;

endmodule

// File: tb/tb_m_extension_unit.sv
// Scoreboard bench for m_extension_unit: directed M-extension vectors with hand-computed results
// and completion cycles; a negedge monitor checks every ready pulse against the queue.
module tb_m_extension_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        invalid_inst = 1'b0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic        busy, ready, wr;
    logic [31:0] result;
    logic [4:0]  dest;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wr;
        int          at;
    } exp_t;

    exp_t q[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;

    localparam int LAT_NORM = 34;
    localparam int LAT_SPEC = 1;

    m_extension_unit dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .invalid_inst(invalid_inst), .op1(op1), .op2(op2),
        .busy(busy), .ready(ready), .wr(wr), .result(result), .dest(dest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Monitor: every ready pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (rst && ready) begin
            if (q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("dest", {27'd0, dest}, {27'd0, e.rd});
                chk("wr", {31'd0, wr}, {31'd0, e.wr});
                chk("ready_cycle", cyc, e.at);
                chk("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("busy_falls", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
        @(negedge clk);
        instruction = mk(7'b0000001, f3, rd);
        op1 = a;
        op2 = b;
        invalid_inst = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op1 = $urandom;
        op2 = $urandom;
        q.push_back('{exp, rd, (rd != 5'd0), cyc + lat});
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_idle();
    endtask

    task automatic no_accept(input logic [31:0] ins, input logic inv);
        @(negedge clk);
        instruction = ins;
        invalid_inst = inv;
        op1 = 32'd9;
        op2 = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        invalid_inst = 1'b0;
        chk("no_accept_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("no_accept_busy_later", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t0;
        logic [31:0] ins;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_wr", {31'd0, wr}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_dest", {27'd0, dest}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, LAT_NORM);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, LAT_NORM);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, LAT_NORM);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, LAT_NORM);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, LAT_NORM);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, LAT_NORM);
        issue(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, LAT_NORM);
        issue(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'd1, LAT_NORM);
        issue(3'b101, 32'd100, 32'd7, 5'd13, 32'd14, LAT_NORM);
        issue(3'b111, 32'd100, 32'd7, 5'd14, 32'd2, LAT_NORM);
        issue(3'b101, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, LAT_SPEC);
        issue(3'b111, 32'd5, 32'd0, 5'd16, 32'd5, LAT_SPEC);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, LAT_SPEC);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, LAT_SPEC);
        issue(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, LAT_NORM);

        // start held high: one accept per operation, second one in the first IDLE cycle
        @(negedge clk);
        instruction = mk(7'b0000001, 3'b000, 5'd20);
        op1 = 32'd3;
        op2 = 32'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        q.push_back('{32'd15, 5'd20, 1'b1, t0 + LAT_NORM});
        op1 = 32'd6;
        op2 = 32'd7;
        while (cyc < t0 + 35) @(negedge clk);
        chk("first_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        q.push_back('{32'd42, 5'd20, 1'b1, t0 + 36 + LAT_NORM});
        wait_idle();

        ins = mk(7'b0000000, 3'b000, 5'd3);
        no_accept(ins, 1'b0);
        ins = mk(7'b0000001, 3'b000, 5'd3);
        ins[6:0] = 7'b0010011;
        no_accept(ins, 1'b0);
        ins = mk(7'b0000001, 3'b000, 5'd3);
        no_accept(ins, 1'b1);

        // reset in the middle of a DIV
        @(negedge clk);
        instruction = mk(7'b0000001, 3'b100, 5'd21);
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_wr", {31'd0, wr}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_dest", {27'd0, dest}, 32'd0);
        repeat (45) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);
        issue(3'b000, 32'd11, 32'd13, 5'd22, 32'd143, LAT_NORM);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
